// File: rtl/sap_bus_seq.sv
// Bus transfer sequencer: debounced go starts a RD->WR (or switch->WR) move; SAP_GO_DEBOUNCE_EN enables the filter.
// Latency: go_db 2+DB_CYCLES cycles after go (3 without filter); mode 0 commits at R+2, mode 1 at R+1.
// Backpressure: hlt freezes RD/WR and masks strobes; go edges outside IDLE or under hlt are dropped.
module sap_bus_seq #(
    parameter int DATA_W    = 8,
    parameter int N_MOD     = 16,
    parameter int DB_CYCLES = 65536,
    localparam int SEL_W    = $clog2(N_MOD)
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    go,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        src_sel,
    input  logic [SEL_W-1:0]        dst_sel,
    input  logic [DATA_W-1:0]       prog_in,
    input  logic [N_MOD*DATA_W-1:0] mod_dout,
    input  logic                    hlt,
    output logic [N_MOD-1:0]        oe,
    output logic [N_MOD-1:0]        we,
    output logic [DATA_W-1:0]       bus_data,
    output logic                    go_db,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;

    logic go_m_q, go_s_q;
    logic go_db_q, go_db_prev_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            go_m_q       <= 1'b0;
            go_s_q       <= 1'b0;
            go_db_prev_q <= 1'b0;
        end else begin
            go_m_q       <= go;
            go_s_q       <= go_m_q;
            go_db_prev_q <= go_db_q;
        end
    end

`ifdef SAP_GO_DEBOUNCE_EN
    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic             go_db_d;

    // Any disagreement that does not persist for DB_CYCLES cycles restarts the count.
    always_comb begin
        db_cnt_d = db_cnt_q;
        go_db_d  = go_db_q;
        if (go_s_q == go_db_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == CNT_W'(DB_CYCLES - 1)) begin
            go_db_d  = ~go_db_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            db_cnt_q <= '0;
            go_db_q  <= 1'b0;
        end else begin
            db_cnt_q <= db_cnt_d;
            go_db_q  <= go_db_d;
        end
    end
`else
    always_ff @(posedge CLK) begin
        if (RESET) begin
            go_db_q <= 1'b0;
        end else begin
            go_db_q <= go_s_q;
        end
    end
`endif

    logic [1:0]        state_q, state_d;
    logic [SEL_W-1:0]  src_q, src_d;
    logic [SEL_W-1:0]  dst_q, dst_d;
    logic [DATA_W-1:0] bus_q, bus_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rd_dat;
    logic              start, dst_bad, src_bad, reject;

    always_comb begin
        rd_dat = '0;
        for (int k = 0; k < N_MOD; k++) begin
            if (src_q == SEL_W'(k)) begin
                rd_dat = mod_dout[k*DATA_W +: DATA_W];
            end
        end
    end

    assign start   = go_db_q && !go_db_prev_q && (state_q == ST_IDLE) && !hlt;
    assign dst_bad = 32'(dst_sel) >= N_MOD;
    assign src_bad = (32'(src_sel) >= N_MOD) || (src_sel == dst_sel);
    assign reject  = dst_bad || (!mode && src_bad);

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        bus_d   = bus_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_d = src_sel;
                    dst_d = dst_sel;
                    if (reject) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = 1'b0;
                        if (mode) begin
                            state_d = ST_WR;
                            bus_d   = prog_in;
                        end else begin
                            state_d = ST_RD;
                        end
                    end
                end
            end
            ST_RD: begin
                if (!hlt) begin
                    bus_d   = rd_dat;
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                if (!hlt) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            bus_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            bus_q   <= bus_d;
            err_q   <= err_d;
        end
    end

    // Strobes are decoded from state so a reset between RD and WR can never leave a write pending.
    always_comb begin
        oe = '0;
        we = '0;
        for (int k = 0; k < N_MOD; k++) begin
            oe[k] = (state_q == ST_RD) && !hlt && (src_q == SEL_W'(k));
            we[k] = (state_q == ST_WR) && !hlt && (dst_q == SEL_W'(k));
        end
    end

    assign bus_data = bus_q;
    assign go_db    = go_db_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_WR) && !hlt;
    assign err      = err_q;

endmodule

// File: tb/tb_sap_bus_seq.sv
// Directed bench for sap_bus_seq with DB_CYCLES=4; expectations follow the build's debounce setting.
module tb_sap_bus_seq;

    localparam int DATA_W = 8;
    localparam int N_MOD  = 16;
    localparam int DB     = 4;
`ifdef SAP_GO_DEBOUNCE_EN
    localparam int LAT    = 2 + DB;
    localparam int N_BNC  = 1;
`else
    localparam int LAT    = 3;
    localparam int N_BNC  = 6;
`endif

    logic                    CLK;
    logic                    RESET;
    logic                    go;
    logic                    mode;
    logic [3:0]              src_sel;
    logic [3:0]              dst_sel;
    logic [DATA_W-1:0]       prog_in;
    logic [N_MOD*DATA_W-1:0] mod_dout;
    logic                    hlt;
    logic [N_MOD-1:0]        oe;
    logic [N_MOD-1:0]        we;
    logic [DATA_W-1:0]       bus_data;
    logic                    go_db;
    logic                    busy;
    logic                    done;
    logic                    err;

    sap_bus_seq #(
        .DATA_W    (DATA_W),
        .N_MOD     (N_MOD),
        .DB_CYCLES (DB)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .go       (go),
        .mode     (mode),
        .src_sel  (src_sel),
        .dst_sel  (dst_sel),
        .prog_in  (prog_in),
        .mod_dout (mod_dout),
        .hlt      (hlt),
        .oe       (oe),
        .we       (we),
        .bus_data (bus_data),
        .go_db    (go_db),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int   n_chk = 0;
    int   n_err = 0;
    logic excl_bad = 1'b0;

    always @(negedge CLK) begin
        if ((|oe) && (|we)) excl_bad <= 1'b1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Returns the number of edges from raising go until go_db is seen high (cycle R).
    task automatic press(output int lat);
        lat = 0;
        go  = 1'b1;
        while (go_db !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        go = 1'b0;
        if (go_db !== 1'b1) chk("go_db_timeout", 64'(go_db), 64'd1);
    endtask

    task automatic settle();
        go = 1'b0;
        repeat (LAT + 4) tick();
    endtask

    initial begin
        int   lat;
        int   rises;
        int   dones;
        int   lat3;
        logic gprev;
        logic we_seen;
        logic busy_seen;

        RESET   = 1'b1;
        go      = 1'b0;
        mode    = 1'b0;
        src_sel = '0;
        dst_sel = '0;
        prog_in = '0;
        hlt     = 1'b0;
        for (int k = 0; k < N_MOD; k++) mod_dout[k*DATA_W +: DATA_W] = 8'(k * 17);
        mod_dout[15:8] = 8'hA5;
        repeat (3) tick();
        chk("rst_outs", {12'd0, oe, we, bus_data, go_db, busy, done, err}, 64'd0);
        RESET = 1'b0;
        tick();
        chk("post_rst_outs", {12'd0, oe, we, bus_data, go_db, busy, done, err}, 64'd0);

        // mode 0: module 1 -> module 2
        mode = 1'b0; src_sel = 4'd1; dst_sel = 4'd2;
        press(lat);
        chk("m0_lat", 64'(lat), 64'(LAT));
        chk("m0_R_busy", 64'(busy), 64'd0);
        tick();
        chk("m0_R1_oe", 64'(oe), 64'h0002);
        chk("m0_R1_we", 64'(we), 64'h0000);
        chk("m0_R1_busy", 64'(busy), 64'd1);
        tick();
        chk("m0_R2_oe", 64'(oe), 64'h0000);
        chk("m0_R2_we", 64'(we), 64'h0004);
        chk("m0_R2_bus", 64'(bus_data), 64'hA5);
        chk("m0_R2_done", 64'(done), 64'd1);
        chk("m0_R2_busy", 64'(busy), 64'd1);
        tick();
        chk("m0_R3_busy", 64'(busy), 64'd0);
        chk("m0_R3_done", 64'(done), 64'd0);
        chk("m0_R3_bus_hold", 64'(bus_data), 64'hA5);
        settle();

        // mode 1: switches -> module 0
        mode = 1'b1; dst_sel = 4'd0; prog_in = 8'h3C;
        press(lat);
        chk("m1_lat", 64'(lat), 64'(LAT));
        chk("m1_R_oe", 64'(oe), 64'h0000);
        tick();
        chk("m1_R1_oe", 64'(oe), 64'h0000);
        chk("m1_R1_we", 64'(we), 64'h0001);
        chk("m1_R1_bus", 64'(bus_data), 64'h3C);
        chk("m1_R1_done", 64'(done), 64'd1);
        chk("m1_R1_busy", 64'(busy), 64'd1);
        tick();
        chk("m1_R2_busy", 64'(busy), 64'd0);
        settle();

        // bouncing go: toggles every 2 cycles for 20 cycles, then held high
        mode = 1'b1; dst_sel = 4'd3; prog_in = 8'h5A;
        rises = 0; dones = 0; lat3 = -1;
        gprev = go_db;
        for (int i = 0; i < 20; i++) begin
            go = ((i / 2) % 2 == 0);
            tick();
            if (go_db && !gprev) rises++;
            gprev = go_db;
            if (done) dones++;
        end
        go = 1'b1;
        for (int j = 1; j <= LAT + 6; j++) begin
            tick();
            if (go_db && !gprev) begin
                rises++;
                lat3 = j;
            end
            gprev = go_db;
            if (done) dones++;
        end
        chk("bnc_rises", 64'(rises), 64'(N_BNC));
        chk("bnc_dones", 64'(dones), 64'(N_BNC));
        chk("bnc_lat", 64'(lat3), 64'(LAT));
        chk("bnc_bus", 64'(bus_data), 64'h5A);
        settle();

        // illegal src==dst, then a valid request clears err
        mode = 1'b0; src_sel = 4'd5; dst_sel = 4'd5;
        press(lat);
        tick();
        chk("rej_err", 64'(err), 64'd1);
        chk("rej_busy", 64'(busy), 64'd0);
        chk("rej_strobes", {32'd0, oe, we}, 64'd0);
        tick();
        chk("rej_strobes2", {32'd0, oe, we}, 64'd0);
        settle();
        src_sel = 4'd5; dst_sel = 4'd6;
        press(lat);
        chk("ok_R_err", 64'(err), 64'd1);
        tick();
        chk("ok_R1_err", 64'(err), 64'd0);
        chk("ok_R1_oe", 64'(oe), 64'h0020);
        tick();
        chk("ok_R2_we", 64'(we), 64'h0040);
        chk("ok_R2_bus", 64'(bus_data), 64'h55);
        chk("ok_R2_done", 64'(done), 64'd1);
        settle();

        // halt for three cycles in RD
        src_sel = 4'd7; dst_sel = 4'd3;
        press(lat);
        tick();
        hlt = 1'b1;
        #1;
        chk("hlt_R1_oe", 64'(oe), 64'h0000);
        chk("hlt_R1_busy", 64'(busy), 64'd1);
        tick();
        chk("hlt_R2_oe", 64'(oe), 64'h0000);
        chk("hlt_R2_bus", 64'(bus_data), 64'h55);
        tick();
        chk("hlt_R3_strobes", {32'd0, oe, we}, 64'd0);
        chk("hlt_R3_done", 64'(done), 64'd0);
        tick();
        hlt = 1'b0;
        #1;
        chk("hlt_R4_oe", 64'(oe), 64'h0080);
        tick();
        chk("hlt_R5_we", 64'(we), 64'h0008);
        chk("hlt_R5_bus", 64'(bus_data), 64'h77);
        chk("hlt_R5_done", 64'(done), 64'd1);
        tick();
        chk("hlt_R6_busy", 64'(busy), 64'd0);
        settle();

        // reset while in RD
        src_sel = 4'd1; dst_sel = 4'd2;
        press(lat);
        tick();
        chk("rstrd_R1_oe", 64'(oe), 64'h0002);
        RESET = 1'b1;
        tick();
        chk("rstrd_busy", 64'(busy), 64'd0);
        chk("rstrd_bus", 64'(bus_data), 64'd0);
        chk("rstrd_outs", {12'd0, oe, we, bus_data, go_db, busy, done, err}, 64'd0);
        tick();
        RESET = 1'b0;
        we_seen = 1'b0;
        busy_seen = 1'b0;
        repeat (10) begin
            tick();
            we_seen   = we_seen | (|we);
            busy_seen = busy_seen | busy;
        end
        chk("rstrd_no_we", 64'(we_seen), 64'd0);
        chk("rstrd_no_busy", 64'(busy_seen), 64'd0);

        chk("oe_we_excl", 64'(excl_bad), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
